mmu_ydrain: RTL and testbench
=============================

# mmu_ydrain

Read-out engine for the Y store of the MMU. The compute cores write results into the Y store as one parallel word of `CORE_N` lanes per address; this block reads a programmed range of those words back and serializes them, one `INTWIDTH` lane per handshake, onto a valid/ready stream toward the external bus side. It sits between the Y store read port and the host/bus interface, and is launched by the MMU sequencer through the `start`/`ready` pair.

## Interface
- `INTWIDTH`, 16, lane (element) width in bits
- `CORE_N`, 8, lanes per Y word
- `VAW`, 10, Y store address width
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `start`  in  1  launch request, accepted only when `start && ready`
- `ready`  out  1  high when idle and able to accept `start`
- `base_addr`  in  VAW  first Y address to read, latched on accept
- `word_cnt`  in  VAW+1  number of Y words to drain (0 .. 2^VAW), latched on accept
- `Y_rd`  out  VAW  Y store read address
- `Y_rd_en`  out  1  Y store read strobe
- `Y_dout`  in  INTWIDTH*CORE_N  Y store read data, valid exactly 1 cycle after `Y_rd_en`
- `o_data`  out  INTWIDTH  serialized lane
- `o_valid`  out  1  `o_data` valid
- `o_ready`  in  1  downstream accepts `o_data` when `o_valid && o_ready`
- `o_last`  out  1  marks the final lane of the final word
- `done`  out  1  one-cycle pulse at the end of a run

## Operation
- States: IDLE, RD, LAT, SEND.
- IDLE: `ready`=1. On `start`, latch `base_addr` into the address counter and `word_cnt` into the remaining counter. If `word_cnt`=0, stay in IDLE and pulse `done` next cycle. Otherwise go to RD.
- RD: `Y_rd_en`=1 and `Y_rd`=address counter for exactly one cycle, then go to LAT.
- LAT: capture `Y_dout` into a `CORE_N`-lane shift register, clear the lane counter, then go to SEND.
- SEND: `o_valid`=1 and `o_data`=current lane. Lanes are sent in order 0..CORE_N-1, with lane 0 = `Y_dout[INTWIDTH-1:0]`. Each handshake advances one lane.
  - On the handshake of lane CORE_N-1: decrement the remaining counter and increment the address counter, modulo 2^VAW.
  - If the remaining count was 1, go to IDLE and pulse `done` in the following cycle. Otherwise go to RD.
- `o_last`=1 only while `o_valid` is presenting lane CORE_N-1 of the final word.
- Backpressure: while `o_valid && !o_ready`, `o_data` and `o_last` hold stable. `o_valid` never drops without a handshake.
- `start` is ignored outside IDLE. `base_addr` and `word_cnt` are sampled only on accept.
- Address wrap: the read following 2^VAW-1 is address 0. `word_cnt`=2^VAW drains the whole store once, starting at `base_addr`.
- Reset at any point, including mid-SEND, aborts the run immediately. Downstream sees `o_valid` drop asynchronously and must discard any partial word.

## Timing
- Reset values: `ready`=1, `Y_rd_en`=0, `Y_rd`=0, `o_valid`=0, `o_data`=0, `o_last`=0, `done`=0. All internal counters and the shift register are 0, state is IDLE.
- Let start be accepted at cycle t0. Then `Y_rd_en` is at t0+1, capture is at t0+2, and the first `o_valid` is at t0+3.
- With `o_ready` held high, one word takes CORE_N+2 cycles. The next word's `Y_rd_en` is in the cycle after the last-lane handshake.
- `done` is high in the cycle after the final handshake. `ready` is high in that same cycle, and a new `start` is accepted there.
- For `word_cnt`=0, `done` is at t0+1 and no `Y_rd_en` occurs.
- All outputs are registered.

## Test plan
- Single word, free-flowing: set INTWIDTH=16, CORE_N=8, Y[5] lanes 0..7 = 0x0001..0x0008, base=5, cnt=1, `o_ready`=1.
  - Response: `Y_rd_en` with `Y_rd`=5 at t0+1; `o_data` 1..8 on t0+3..t0+10; `o_last` only with 8; `done` at t0+11.
- Backpressure: same data with `o_ready` toggled 1,0,0,1,...
  - Response: every lane appears exactly once in order; `o_data` and `o_valid` stay stable through low `o_ready`; no lane is lost or duplicated.
- Wrap-around: VAW=10, base=1022, cnt=4.
  - Response: reads occur at 1022, 1023, 0, 1; 32 lanes total; `o_last` fires once, on the 32nd lane.
- Zero count: base=3, cnt=0.
  - Response: `done` at t0+1, `Y_rd_en` never asserts, `o_valid` stays 0, `ready` stays 1.
- Start while busy, then reset: pulse `start` with base=0 during SEND of a cnt=3 run; addresses must not change. Then assert `rst_n`=0 mid-SEND.
  - Response: all outputs return to reset values; after release, a new run with base=7, cnt=1 reads address 7.
- Back-to-back: issue `start` in the same cycle as `done`.
  - Response: the second run's `Y_rd_en` appears the cycle after acceptance, with no lost words across runs.

Source files
------------

// File: rtl/mmu_ydrain_if.sv
// rtl/mmu_ydrain_if.sv - Y drain launch, Y store read port and lane stream bundle
interface mmu_ydrain_if #(
  parameter int INTWIDTH = 16,
  parameter int CORE_N   = 8,
  parameter int VAW      = 10
);
  logic                       start;
  logic                       ready;
  logic [VAW-1:0]             base_addr;
  logic [VAW:0]               word_cnt;
  logic [VAW-1:0]             Y_rd;
  logic                       Y_rd_en;
  logic [INTWIDTH*CORE_N-1:0] Y_dout;
  logic [INTWIDTH-1:0]        o_data;
  logic                       o_valid;
  logic                       o_ready;
  logic                       o_last;
  logic                       done;

  modport slave (
    input  start, base_addr, word_cnt, Y_dout, o_ready,
    output ready, Y_rd, Y_rd_en, o_data, o_valid, o_last, done
  );

  modport master (
    output start, base_addr, word_cnt, Y_dout, o_ready,
    input  ready, Y_rd, Y_rd_en, o_data, o_valid, o_last, done
  );
endinterface

// File: rtl/mmu_ydrain.sv
// rtl/mmu_ydrain.sv - Y store read-out and lane serializer
module mmu_ydrain #(
  parameter int INTWIDTH = 16,
  parameter int CORE_N   = 8,
  parameter int VAW      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  mmu_ydrain_if.slave  bus
);
  localparam int WW = INTWIDTH * CORE_N;
  localparam int LW = (CORE_N > 1) ? $clog2(CORE_N) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(CORE_N - 1);
  localparam logic [VAW:0]  REM_ONE   = (VAW+1)'(1);

  typedef enum logic [1:0] {IDLE, RD, LAT, SEND} state_t;

  state_t              r_state, w_state_nxt;
  logic [VAW-1:0]      r_addr, w_addr_nxt;
  logic [VAW:0]        r_rem, w_rem_nxt;
  logic [LW-1:0]       r_lane, w_lane_nxt;
  logic [WW-1:0]       r_shift, w_shift_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_y_rd_en, w_y_rd_en_nxt;
  logic [VAW-1:0]      r_y_rd, w_y_rd_nxt;
  logic                r_o_valid, w_o_valid_nxt;
  logic [INTWIDTH-1:0] r_o_data, w_o_data_nxt;
  logic                r_o_last, w_o_last_nxt;
  logic                r_done, w_done_nxt;
  logic                w_hs;

  assign w_hs = r_o_valid && bus.o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_lane    <= '0;
      r_shift   <= '0;
      r_ready   <= 1'b1;
      r_y_rd_en <= 1'b0;
      r_y_rd    <= '0;
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_last  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_rem     <= w_rem_nxt;
      r_lane    <= w_lane_nxt;
      r_shift   <= w_shift_nxt;
      r_ready   <= w_ready_nxt;
      r_y_rd_en <= w_y_rd_en_nxt;
      r_y_rd    <= w_y_rd_nxt;
      r_o_valid <= w_o_valid_nxt;
      r_o_data  <= w_o_data_nxt;
      r_o_last  <= w_o_last_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Every output is computed one cycle early so the ports come straight off flops.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_rem_nxt     = r_rem;
    w_lane_nxt    = r_lane;
    w_shift_nxt   = r_shift;
    w_ready_nxt   = r_ready;
    w_y_rd_en_nxt = 1'b0;
    w_y_rd_nxt    = r_y_rd;
    w_o_valid_nxt = r_o_valid;
    w_o_data_nxt  = r_o_data;
    w_o_last_nxt  = r_o_last;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && r_ready) begin
          w_addr_nxt = bus.base_addr;
          w_rem_nxt  = bus.word_cnt;
          if (bus.word_cnt == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt   = RD;
            w_ready_nxt   = 1'b0;
            w_y_rd_en_nxt = 1'b1;
            w_y_rd_nxt    = bus.base_addr;
          end
        end
      end
      RD: w_state_nxt = LAT;
      LAT: begin
        w_shift_nxt   = bus.Y_dout;
        w_lane_nxt    = '0;
        w_o_valid_nxt = 1'b1;
        w_o_data_nxt  = bus.Y_dout[INTWIDTH-1:0];
        w_o_last_nxt  = (CORE_N == 1) && (r_rem == REM_ONE);
        w_state_nxt   = SEND;
      end
      SEND: begin
        if (w_hs) begin
          if (r_lane == LAST_LANE) begin
            w_rem_nxt     = r_rem - 1'b1;
            w_addr_nxt    = r_addr + 1'b1;
            w_o_valid_nxt = 1'b0;
            w_o_last_nxt  = 1'b0;
            if (r_rem == REM_ONE) begin
              w_state_nxt = IDLE;
              w_ready_nxt = 1'b1;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt   = RD;
              w_y_rd_en_nxt = 1'b1;
              w_y_rd_nxt    = r_addr + 1'b1;
            end
          end else begin
            // Lane 0 of the shift register always holds the lane on the wire.
            w_lane_nxt   = r_lane + 1'b1;
            w_shift_nxt  = r_shift >> INTWIDTH;
            w_o_data_nxt = w_shift_nxt[INTWIDTH-1:0];
            w_o_last_nxt = (w_lane_nxt == LAST_LANE) && (r_rem == REM_ONE);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ready   = r_ready;
  assign bus.Y_rd_en = r_y_rd_en;
  assign bus.Y_rd    = r_y_rd;
  assign bus.o_valid = r_o_valid;
  assign bus.o_data  = r_o_data;
  assign bus.o_last  = r_o_last;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_mmu_ydrain.sv
// tb/tb_mmu_ydrain.sv - randomized scoreboard bench for mmu_ydrain
module tb_mmu_ydrain;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mode = 0;
  int   exp_done = 0;
  int   done_cnt = 0;
  int   n_rd = 0;
  int   n_lane = 0;
  int   n_last = 0;
  int   rd_cyc = 0;
  int   valid_cyc = 0;
  int   done_cyc = 0;
  int   t0 = 0;
  logic [9:0]   last_rd_addr = '0;
  logic [127:0] mem [1024];
  logic [9:0]   exp_addr_q [$];
  logic [16:0]  exp_lane_q [$];

  mmu_ydrain_if #(.INTWIDTH(16), .CORE_N(8), .VAW(10)) bus ();

  mmu_ydrain #(.INTWIDTH(16), .CORE_N(8), .VAW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Y store: read data appears the cycle after the strobe.
  initial begin
    bus.Y_dout = '0;
    forever begin
      @(posedge clk);
      if (bus.Y_rd_en) bus.Y_dout <= mem[bus.Y_rd];
    end
  end

  // Downstream acceptance: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    int k;
    k = 0;
    bus.o_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1:       bus.o_ready = (k % 4 == 0) || (k % 4 == 3);
        2:       bus.o_ready = 1'($urandom_range(0, 1));
        default: bus.o_ready = 1'b1;
      endcase
      k++;
    end
  end

  // Monitor: pops expectations whenever the DUT reads or hands over a lane.
  initial begin
    logic        prev_stall;
    logic        prev_valid;
    logic [15:0] held_data;
    logic        held_last;
    logic [16:0] e;
    prev_stall = 1'b0;
    prev_valid = 1'b0;
    held_data  = '0;
    held_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(bus.o_valid), 32'd1);
          chk("stall_data", 32'(bus.o_data), 32'(held_data));
          chk("stall_last", 32'(bus.o_last), 32'(held_last));
        end
        if (bus.Y_rd_en) begin
          n_rd++;
          rd_cyc = cyc;
          last_rd_addr = bus.Y_rd;
          if (exp_addr_q.size() == 0) chk("unexpected_rd", 32'(bus.Y_rd_en), 32'd0);
          else chk("rd_addr", 32'(bus.Y_rd), 32'(exp_addr_q.pop_front()));
        end
        if (bus.o_valid && !prev_valid) valid_cyc = cyc;
        if (bus.o_valid && bus.o_ready) begin
          n_lane++;
          if (bus.o_last) n_last++;
          if (exp_lane_q.size() == 0) begin
            chk("unexpected_lane", 32'(bus.o_valid), 32'd0);
          end else begin
            e = exp_lane_q.pop_front();
            chk("lane_data", 32'(bus.o_data), 32'(e[15:0]));
            chk("lane_last", 32'(bus.o_last), 32'(e[16]));
          end
        end
        prev_stall = bus.o_valid && !bus.o_ready;
        held_data  = bus.o_data;
        held_last  = bus.o_last;
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
      prev_valid = bus.o_valid;
    end
  end

  // Reference: word w of a run comes from (base+w) mod 1024, lanes low to high.
  task automatic model_run(input int base, input int cnt);
    int a;
    for (int w = 0; w < cnt; w++) begin
      a = (base + w) % 1024;
      exp_addr_q.push_back(10'(a));
      for (int l = 0; l < 8; l++)
        exp_lane_q.push_back({(w == cnt - 1) && (l == 7), mem[a][l*16 +: 16]});
    end
  endtask

  task automatic issue(input int base, input int cnt);
    int n;
    n = 0;
    while (!bus.ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_wait", 32'(bus.ready), 32'd1);
    model_run(base, cnt);
    exp_done++;
    bus.start     = 1'b1;
    bus.base_addr = 10'(base);
    bus.word_cnt  = 11'(cnt);
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt < exp_done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    @(posedge clk);
    #1;
    chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("lane_q_empty", 32'(exp_lane_q.size()), 32'd0);
  endtask

  task automatic check_reset();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_rd_en", 32'(bus.Y_rd_en), 32'd0);
    chk("rst_rd", 32'(bus.Y_rd), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data", 32'(bus.o_data), 32'd0);
    chk("rst_last", 32'(bus.o_last), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rd0, lane0, last0, n, t0a;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_cnt = '0;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int l = 0; l < 8; l++) mem[5][l*16 +: 16] = 16'(l + 1);
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, free-flowing: exact latencies.
    mode = 0;
    lane0 = n_lane;
    last0 = n_last;
    issue(5, 1);
    wait_done(100);
    chk("t1_rd_lat", 32'(rd_cyc - t0), 32'd1);
    chk("t1_rd_addr", 32'(last_rd_addr), 32'd5);
    chk("t1_valid_lat", 32'(valid_cyc - t0), 32'd3);
    chk("t1_done_lat", 32'(done_cyc - t0), 32'd11);
    chk("t1_lanes", 32'(n_lane - lane0), 32'd8);
    chk("t1_lasts", 32'(n_last - last0), 32'd1);

    // Backpressure.
    mode = 1;
    issue(5, 1);
    wait_done(200);
    issue(20, 3);
    wait_done(500);

    // Address wrap.
    mode = 2;
    rd0 = n_rd;
    lane0 = n_lane;
    last0 = n_last;
    issue(1022, 4);
    wait_done(1000);
    chk("wrap_reads", 32'(n_rd - rd0), 32'd4);
    chk("wrap_lanes", 32'(n_lane - lane0), 32'd32);
    chk("wrap_lasts", 32'(n_last - last0), 32'd1);

    // Zero count.
    rd0 = n_rd;
    issue(3, 0);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_ready", 32'(bus.ready), 32'd1);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("zero_valid", 32'(bus.o_valid), 32'd0);
      chk("zero_idle_ready", 32'(bus.ready), 32'd1);
    end
    chk("zero_reads", 32'(n_rd - rd0), 32'd0);
    chk("zero_done_count", 32'(done_cnt), 32'(exp_done));

    // Start while busy, then reset mid-SEND.
    rd0 = n_rd;
    issue(10, 3);
    n = 0;
    while (!(bus.o_valid && n_rd - rd0 >= 1) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_in_send", 32'(bus.o_valid), 32'd1);
    chk("busy_ready", 32'(bus.ready), 32'd0);
    bus.start = 1'b1;
    bus.base_addr = 10'd0;
    bus.word_cnt = 11'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (!(bus.o_valid && n_rd - rd0 >= 2) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("second_word_send", 32'(bus.o_valid), 32'd1);
    chk("busy_second_addr", 32'(last_rd_addr), 32'd11);
    rst_n = 1'b0;
    #1;
    check_reset();
    exp_addr_q.delete();
    exp_lane_q.delete();
    exp_done = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(7, 1);
    wait_done(200);
    chk("post_rst_addr", 32'(last_rd_addr), 32'd7);

    // Back-to-back: second start lands in the done cycle of the first.
    mode = 0;
    issue(100, 2);
    t0a = t0;
    while (cyc < t0a + 21) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_done", 32'(bus.done), 32'd1);
    chk("b2b_ready", 32'(bus.ready), 32'd1);
    issue(200, 3);
    chk("b2b_rd_en", 32'(bus.Y_rd_en), 32'd1);
    chk("b2b_rd_addr", 32'(bus.Y_rd), 32'd200);
    wait_done(500);
    chk("b2b_done_lat", 32'(done_cyc - t0), 32'd31);

    // Whole store in one run.
    rd0 = n_rd;
    issue(int'($urandom_range(0, 1023)), 1024);
    wait_done(12000);
    chk("full_reads", 32'(n_rd - rd0), 32'd1024);

    // Random runs.
    for (int r = 0; r < 8; r++) begin
      mode = int'($urandom_range(0, 2));
      issue(int'($urandom_range(0, 1023)), int'($urandom_range(1, 6)));
      wait_done(2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
